// File: rtl/exu_issue_ctrl.sv
// Issue controller: ID handshake, 32-entry busy scoreboard, in-flight writer limit, one-entry EX register.
// Latency: accepted instruction appears on ex_* one cycle after the accept edge.
// Backpressure: id_ready_o drops on hazard, full counter, flush or a held EX entry that EXU is not taking.
module exu_issue_ctrl #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 id_valid_i,
    output logic                 id_ready_o,
    input  logic                 id_ers1_i,
    input  logic                 id_ers2_i,
    input  logic [2:0]           id_specinst_i,
    input  logic [4:0]           id_rs1_i,
    input  logic [4:0]           id_rs2_i,
    input  logic [4:0]           id_rd_i,
    input  logic                 id_rd_we_i,
    output logic                 ex_valid_o,
    input  logic                 ex_ready_i,
    output logic                 ex_ers1_o,
    output logic                 ex_ers2_o,
    output logic [2:0]           ex_specinst_o,
    output logic [4:0]           ex_rd_o,
    output logic                 ex_rd_we_o,
    input  logic                 wb_valid_i,
    input  logic [4:0]           wb_rd_i,
    input  logic                 flush_i,
    output logic [CNT_WIDTH-1:0] inflight_o
);

    localparam logic [0:0] EMPTY     = 1'b0;
    localparam logic [0:0] HELD      = 1'b1;
    localparam logic [2:0] SPEC_JALR = 3'd2;

    logic [0:0]           state;
    logic [0:0]           state_nxt;
    logic [31:0]          busy;
    logic [31:0]          busy_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;

    logic       use1;
    logic       use2;
    logic       hazard;
    logic       full;
    logic       accept;
    logic       id_set;
    logic       wb_clr;
    logic       wb_dec;
    logic       fl_clr;
    logic [1:0] dec;

    assign use1   = id_ers1_i | (id_specinst_i == SPEC_JALR);
    assign use2   = id_ers2_i;
    assign hazard = (use1 & busy[id_rs1_i]) | (use2 & busy[id_rs2_i]);
    assign full   = (cnt == CNT_WIDTH'(MAX_INFLIGHT)) & id_rd_we_i;

    assign id_ready_o = rst_n_i & ~hazard & ~full & ~flush_i & ((state == EMPTY) | ex_ready_i);
    assign accept     = id_valid_i & id_ready_o;

    assign id_set = accept & id_rd_we_i & (id_rd_i != 5'd0);
    assign wb_clr = wb_valid_i & (wb_rd_i != 5'd0);
    assign wb_dec = wb_clr & (cnt != '0);
    // A flushed writer never reaches writeback, so it must release its own slot.
    assign fl_clr = flush_i & (state == HELD) & ex_rd_we_o & (ex_rd_o != 5'd0);
    assign dec    = {1'b0, wb_dec} + {1'b0, fl_clr};

    always_comb begin
        busy_nxt = busy;
        if (wb_clr) busy_nxt[wb_rd_i] = 1'b0;
        if (fl_clr) busy_nxt[ex_rd_o] = 1'b0;
        // Set after clears: a new writer of the same rd owns the bit.
        if (id_set) busy_nxt[id_rd_i] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = cnt;
        if (id_set) begin
            if (dec == 2'd0)
                cnt_nxt = cnt + CNT_WIDTH'(1);
            else if (dec == 2'd2)
                cnt_nxt = cnt - CNT_WIDTH'(1);
        end else if (cnt > CNT_WIDTH'(dec)) begin
            cnt_nxt = cnt - CNT_WIDTH'(dec);
        end else begin
            cnt_nxt = '0;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush_i)
            state_nxt = EMPTY;
        else if (accept)
            state_nxt = HELD;
        else if (ex_ready_i)
            state_nxt = EMPTY;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= EMPTY;
            busy  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_ers1_o     <= 1'b0;
            ex_ers2_o     <= 1'b0;
            ex_specinst_o <= 3'd0;
            ex_rd_o       <= 5'd0;
            ex_rd_we_o    <= 1'b0;
        end else if (accept) begin
            ex_ers1_o     <= id_ers1_i;
            ex_ers2_o     <= id_ers2_i;
            ex_specinst_o <= id_specinst_i;
            ex_rd_o       <= id_rd_i;
            ex_rd_we_o    <= id_rd_we_i;
        end
    end

    assign ex_valid_o = (state == HELD);
    assign inflight_o = cnt;

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// Bench for exu_issue_ctrl: directed scenarios plus a randomized run against a set/counter reference model.
module tb_exu_issue_ctrl;

    localparam int MAX = 4;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       id_valid_i, id_ready_o, id_ers1_i, id_ers2_i, id_rd_we_i;
    logic [2:0] id_specinst_i;
    logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic       ex_valid_o, ex_ready_i, ex_ers1_o, ex_ers2_o, ex_rd_we_o;
    logic [2:0] ex_specinst_o;
    logic [4:0] ex_rd_o;
    logic       wb_valid_i, flush_i;
    logic [4:0] wb_rd_i;
    logic [3:0] inflight_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: set of busy registers, writer count, EX slot contents.
    bit         m_busy[32];
    int         m_cnt;
    bit         m_exv, m_ers1, m_ers2, m_we;
    logic [2:0] m_spec;
    logic [4:0] m_rd;

    always #5 clk_i = ~clk_i;

    exu_issue_ctrl #(.MAX_INFLIGHT(MAX), .CNT_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_ers1_i(id_ers1_i), .id_ers2_i(id_ers2_i), .id_specinst_i(id_specinst_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_rd_we_i(id_rd_we_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_ers1_o(ex_ers1_o), .ex_ers2_o(ex_ers2_o), .ex_specinst_o(ex_specinst_o),
        .ex_rd_o(ex_rd_o), .ex_rd_we_o(ex_rd_we_o),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .flush_i(flush_i),
        .inflight_o(inflight_o)
    );

    function automatic bit m_ready();
        bit reads_a, reads_b, blocked, no_slot;
        reads_a = id_ers1_i || (id_specinst_i == 3'd2);
        reads_b = id_ers2_i;
        blocked = (reads_a && id_rs1_i != 5'd0 && m_busy[id_rs1_i]) ||
                  (reads_b && id_rs2_i != 5'd0 && m_busy[id_rs2_i]);
        no_slot = (m_cnt == MAX) && id_rd_we_i;
        return !blocked && !no_slot && !flush_i && (!m_exv || ex_ready_i);
    endfunction

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_cnt = 0; m_exv = 0; m_ers1 = 0; m_ers2 = 0; m_we = 0; m_spec = 3'd0; m_rd = 5'd0;
    endtask

    task automatic idle();
        id_valid_i = 0; id_ers1_i = 0; id_ers2_i = 0; id_specinst_i = 3'd0;
        id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_rd_i = 5'd0; id_rd_we_i = 0;
        ex_ready_i = 1; wb_valid_i = 0; wb_rd_i = 5'd0; flush_i = 0;
    endtask

    task automatic set_id(input bit v, input bit e1, input bit e2, input logic [2:0] sp,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd, input bit we);
        id_valid_i = v; id_ers1_i = e1; id_ers2_i = e2; id_specinst_i = sp;
        id_rs1_i = r1; id_rs2_i = r2; id_rd_i = rd; id_rd_we_i = we;
    endtask

    // One clock: the model absorbs this cycle's inputs, then outputs settle for sampling.
    task automatic tick();
        bit acc, setw, fl, wbd;
        int n;
        acc  = id_valid_i && m_ready();
        setw = acc && id_rd_we_i && (id_rd_i != 5'd0);
        fl   = flush_i && m_exv && m_we && (m_rd != 5'd0);
        wbd  = wb_valid_i && (wb_rd_i != 5'd0) && (m_cnt > 0);
        n    = m_cnt + int'(setw) - int'(wbd) - int'(fl);
        if (n < 0) n = 0;
        @(posedge clk_i);
        if (wb_valid_i && wb_rd_i != 5'd0) m_busy[wb_rd_i] = 1'b0;
        if (fl) m_busy[m_rd] = 1'b0;
        if (setw) m_busy[id_rd_i] = 1'b1;
        m_cnt = n;
        if (flush_i) m_exv = 0;
        else if (acc) begin
            m_exv = 1; m_ers1 = id_ers1_i; m_ers2 = id_ers2_i;
            m_spec = id_specinst_i; m_rd = id_rd_i; m_we = id_rd_we_i;
        end else if (ex_ready_i) m_exv = 0;
        #1;
    endtask

    task automatic test_reset();
        rst_n_i = 0;
        idle();
        set_id(1, 1, 1, 3'd0, 5'd1, 5'd2, 5'd3, 1);
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++; if (id_ready_o !== 1'b0) $display("FAIL reset_ready got=%b exp=0", id_ready_o); else n_pass++;
        n_checks++; if (ex_valid_o !== 1'b0) $display("FAIL reset_exv got=%b exp=0", ex_valid_o); else n_pass++;
        n_checks++; if (inflight_o !== 4'd0) $display("FAIL reset_inflight got=%0d exp=0", inflight_o); else n_pass++;
        n_checks++; if ({ex_ers1_o, ex_ers2_o, ex_specinst_o, ex_rd_o, ex_rd_we_o} !== 11'd0)
            $display("FAIL reset_fields got=%h exp=0", {ex_ers1_o, ex_ers2_o, ex_specinst_o, ex_rd_o, ex_rd_we_o}); else n_pass++;
        idle();
        rst_n_i = 1;
        model_reset();
        #1;
        n_checks++; if (id_ready_o !== 1'b1) $display("FAIL post_reset_ready got=%b exp=1", id_ready_o); else n_pass++;
    endtask

    task automatic test_add();
        set_id(1, 1, 1, 3'd0, 5'd1, 5'd2, 5'd3, 1);
        #1;
        n_checks++; if (id_ready_o !== 1'b1) $display("FAIL add_ready got=%b exp=1", id_ready_o); else n_pass++;
        tick();
        idle();
        #1;
        n_checks++; if (ex_valid_o !== 1'b1) $display("FAIL add_exv got=%b exp=1", ex_valid_o); else n_pass++;
        n_checks++; if ({ex_ers1_o, ex_ers2_o, ex_rd_o, ex_rd_we_o} !== {1'b1, 1'b1, 5'd3, 1'b1})
            $display("FAIL add_fields got=%b%b rd=%0d we=%b exp=11 rd=3 we=1", ex_ers1_o, ex_ers2_o, ex_rd_o, ex_rd_we_o); else n_pass++;
        n_checks++; if (inflight_o !== 4'd1) $display("FAIL add_inflight got=%0d exp=1", inflight_o); else n_pass++;
        set_id(0, 1, 0, 3'd0, 5'd3, 5'd0, 5'd0, 0);
        #1;
        n_checks++; if (id_ready_o !== 1'b0) $display("FAIL add_busy3_rs1 got=%b exp=0", id_ready_o); else n_pass++;
        set_id(0, 0, 1, 3'd0, 5'd0, 5'd3, 5'd0, 0);
        #1;
        n_checks++; if (id_ready_o !== 1'b0) $display("FAIL add_busy3_rs2 got=%b exp=0", id_ready_o); else n_pass++;
        idle();
        wb_valid_i = 1; wb_rd_i = 5'd3;
        tick();
        idle();
        #1;
        n_checks++; if (inflight_o !== 4'd0 || ex_valid_o !== 1'b0)
            $display("FAIL add_cleanup inflight=%0d exv=%b exp=0,0", inflight_o, ex_valid_o); else n_pass++;
    endtask

    task automatic test_raw();
        set_id(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd5, 1);
        #1;
        tick();
        set_id(1, 1, 0, 3'd0, 5'd5, 5'd0, 5'd6, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (id_ready_o !== 1'b0) $display("FAIL raw_stall%0d got=%b exp=0", i, id_ready_o); else n_pass++;
            tick();
        end
        wb_valid_i = 1; wb_rd_i = 5'd5;
        #1;
        n_checks++; if (id_ready_o !== 1'b0) $display("FAIL raw_no_bypass got=%b exp=0", id_ready_o); else n_pass++;
        tick();
        wb_valid_i = 0;
        #1;
        n_checks++; if (inflight_o !== 4'd0) $display("FAIL raw_inflight0 got=%0d exp=0", inflight_o); else n_pass++;
        n_checks++; if (id_ready_o !== 1'b1) $display("FAIL raw_release got=%b exp=1", id_ready_o); else n_pass++;
        tick();
        idle();
        #1;
        n_checks++; if (ex_valid_o !== 1'b1 || ex_rd_o !== 5'd6 || inflight_o !== 4'd1)
            $display("FAIL raw_issue exv=%b rd=%0d inflight=%0d exp=1,6,1", ex_valid_o, ex_rd_o, inflight_o); else n_pass++;
        wb_valid_i = 1; wb_rd_i = 5'd6;
        tick();
        idle();
    endtask

    task automatic test_backpressure();
        set_id(1, 0, 0, 3'd3, 5'd0, 5'd0, 5'd0, 1);
        ex_ready_i = 0;
        #1;
        tick();
        set_id(1, 1, 1, 3'd0, 5'd1, 5'd2, 5'd0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (id_ready_o !== 1'b0) $display("FAIL bp_ready%0d got=%b exp=0", i, id_ready_o); else n_pass++;
            n_checks++; if (ex_valid_o !== 1'b1 || ex_specinst_o !== 3'd3)
                $display("FAIL bp_hold%0d exv=%b spec=%0d exp=1,3", i, ex_valid_o, ex_specinst_o); else n_pass++;
            tick();
        end
        n_checks++; if (inflight_o !== 4'd0) $display("FAIL bp_rd0_inflight got=%0d exp=0", inflight_o); else n_pass++;
        ex_ready_i = 1;
        #1;
        n_checks++; if (id_ready_o !== 1'b1) $display("FAIL bp_resume got=%b exp=1", id_ready_o); else n_pass++;
        tick();
        idle();
        #1;
        n_checks++; if (ex_valid_o !== 1'b1 || ex_specinst_o !== 3'd0 || ex_ers1_o !== 1'b1)
            $display("FAIL bp_next exv=%b spec=%0d ers1=%b exp=1,0,1", ex_valid_o, ex_specinst_o, ex_ers1_o); else n_pass++;
        tick();
    endtask

    task automatic test_full();
        int rds[4] = '{2, 3, 4, 10};
        for (int i = 1; i <= 4; i++) begin
            set_id(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'(i), 1);
            #1;
            n_checks++; if (id_ready_o !== 1'b1) $display("FAIL full_fill%0d got=%b exp=1", i, id_ready_o); else n_pass++;
            tick();
        end
        set_id(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd10, 1);
        #1;
        n_checks++; if (inflight_o !== 4'd4) $display("FAIL full_count got=%0d exp=4", inflight_o); else n_pass++;
        n_checks++; if (id_ready_o !== 1'b0) $display("FAIL full_stall got=%b exp=0", id_ready_o); else n_pass++;
        tick();
        set_id(1, 1, 1, 3'd5, 5'd0, 5'd11, 5'd0, 0);
        #1;
        n_checks++; if (id_ready_o !== 1'b1) $display("FAIL full_store_ready got=%b exp=1", id_ready_o); else n_pass++;
        tick();
        idle();
        #1;
        n_checks++; if (ex_specinst_o !== 3'd5 || ex_rd_we_o !== 1'b0 || inflight_o !== 4'd4)
            $display("FAIL full_store spec=%0d we=%b inflight=%0d exp=5,0,4", ex_specinst_o, ex_rd_we_o, inflight_o); else n_pass++;
        set_id(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd10, 1);
        wb_valid_i = 1; wb_rd_i = 5'd1;
        #1;
        n_checks++; if (id_ready_o !== 1'b0) $display("FAIL full_wb_same_cycle got=%b exp=0", id_ready_o); else n_pass++;
        tick();
        wb_valid_i = 0;
        #1;
        n_checks++; if (inflight_o !== 4'd3 || id_ready_o !== 1'b1)
            $display("FAIL full_admit inflight=%0d ready=%b exp=3,1", inflight_o, id_ready_o); else n_pass++;
        tick();
        idle();
        #1;
        n_checks++; if (inflight_o !== 4'd4 || ex_rd_o !== 5'd10)
            $display("FAIL full_refill inflight=%0d rd=%0d exp=4,10", inflight_o, ex_rd_o); else n_pass++;
        foreach (rds[i]) begin
            wb_valid_i = 1; wb_rd_i = 5'(rds[i]);
            tick();
        end
        idle();
        #1;
        n_checks++; if (inflight_o !== 4'd0) $display("FAIL full_drain got=%0d exp=0", inflight_o); else n_pass++;
    endtask

    task automatic test_flush();
        set_id(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd1, 1);
        #1;
        tick();
        set_id(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd7, 1);
        #1;
        tick();
        set_id(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 0);
        ex_ready_i = 0; flush_i = 1; wb_valid_i = 1; wb_rd_i = 5'd1;
        #1;
        n_checks++; if (inflight_o !== 4'd2) $display("FAIL flush_pre_inflight got=%0d exp=2", inflight_o); else n_pass++;
        n_checks++; if (id_ready_o !== 1'b0) $display("FAIL flush_blocks got=%b exp=0", id_ready_o); else n_pass++;
        tick();
        idle();
        #1;
        n_checks++; if (ex_valid_o !== 1'b0 || inflight_o !== 4'd0)
            $display("FAIL flush_result exv=%b inflight=%0d exp=0,0", ex_valid_o, inflight_o); else n_pass++;
        set_id(0, 1, 1, 3'd0, 5'd7, 5'd1, 5'd0, 0);
        #1;
        n_checks++; if (id_ready_o !== 1'b1) $display("FAIL flush_busy_cleared got=%b exp=1", id_ready_o); else n_pass++;
        idle();
        flush_i = 1;
        tick();
        idle();
        #1;
        n_checks++; if (ex_valid_o !== 1'b0 || inflight_o !== 4'd0)
            $display("FAIL flush_empty exv=%b inflight=%0d exp=0,0", ex_valid_o, inflight_o); else n_pass++;
    endtask

    task automatic test_collision();
        set_id(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd9, 1);
        #1;
        tick();
        set_id(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd9, 1);
        wb_valid_i = 1; wb_rd_i = 5'd9;
        #1;
        n_checks++; if (id_ready_o !== 1'b1) $display("FAIL coll_ready got=%b exp=1", id_ready_o); else n_pass++;
        tick();
        idle();
        #1;
        n_checks++; if (inflight_o !== 4'd1) $display("FAIL coll_inflight got=%0d exp=1", inflight_o); else n_pass++;
        set_id(0, 0, 0, 3'd2, 5'd9, 5'd0, 5'd0, 0);
        #1;
        n_checks++; if (id_ready_o !== 1'b0) $display("FAIL coll_jalr_stall got=%b exp=0", id_ready_o); else n_pass++;
        set_id(0, 0, 0, 3'd0, 5'd9, 5'd0, 5'd0, 0);
        #1;
        n_checks++; if (id_ready_o !== 1'b1) $display("FAIL coll_no_read got=%b exp=1", id_ready_o); else n_pass++;
        idle();
        wb_valid_i = 1; wb_rd_i = 5'd9;
        tick();
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            set_id(($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom));
            ex_ready_i = ($urandom_range(0, 9) < 7);
            wb_valid_i = ($urandom_range(0, 2) == 0);
            wb_rd_i    = 5'($urandom_range(0, 7));
            flush_i    = ($urandom_range(0, 15) == 0);
            #1;
            n_checks++; if (id_ready_o !== m_ready())
                $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, id_ready_o, m_ready()); else n_pass++;
            tick();
            n_checks++; if (ex_valid_o !== m_exv || inflight_o !== 4'(m_cnt))
                $display("FAIL rnd_state c=%0d exv=%b inflight=%0d exp=%b,%0d", c, ex_valid_o, inflight_o, m_exv, m_cnt); else n_pass++;
            if (m_exv) begin
                n_checks++; if ({ex_ers1_o, ex_ers2_o, ex_specinst_o, ex_rd_o, ex_rd_we_o} !== {m_ers1, m_ers2, m_spec, m_rd, m_we})
                    $display("FAIL rnd_fields c=%0d got=%h exp=%h", c, {ex_ers1_o, ex_ers2_o, ex_specinst_o, ex_rd_o, ex_rd_we_o},
                             {m_ers1, m_ers2, m_spec, m_rd, m_we}); else n_pass++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add();
        test_raw();
        test_backpressure();
        test_full();
        test_flush();
        test_collision();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
